// File: rtl/onehot_mux_reg_if.sv
// Bus bundle for onehot_mux_reg: channel data and select in, registered selection
// and status out.
interface onehot_mux_reg_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 8
);
  localparam int IW = $clog2(N);

  logic [N*W-1:0] data_in;
  logic [N-1:0]   sel;
  logic           clr_err;
  logic [W-1:0]   out;
  logic           out_valid;
  logic           changed;
  logic [IW-1:0]  src_idx;
  logic           conflict;
  logic [CW-1:0]  hold_cnt;

  modport master (
    output data_in, sel, clr_err,
    input  out, out_valid, changed, src_idx, conflict, hold_cnt
  );

  modport slave (
    input  data_in, sel, clr_err,
    output out, out_valid, changed, src_idx, conflict, hold_cnt
  );
endinterface

// File: rtl/onehot_mux_reg.sv
// Registered N-way select mux with sticky multi-select detection and a saturating
// cycles-since-capture counter.
module onehot_mux_reg #(
  parameter int N      = 4,
  parameter int W      = 8,
  parameter int STRICT = 0,
  parameter int CW     = 8
) (
  input logic              clk,
  input logic              rst,
  onehot_mux_reg_if.slave  bus
);
  localparam int IW = $clog2(N);

  // Lowest set bit wins; returns 0 for an empty vector (caller gates on hit).
  function automatic logic [IW-1:0] lowest_idx(input logic [N-1:0] s);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (s[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  function automatic logic multi_hot(input logic [N-1:0] s);
    return (s & (s - 1'b1)) != '0;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic          hit_p0;
  logic          multi_p0;
  logic          accept_p0;
  logic [IW-1:0] idx_p0;
  logic [W-1:0]  data_p0;

  always_comb begin
    hit_p0    = bus.sel != '0;
    multi_p0  = multi_hot(bus.sel);
    accept_p0 = hit_p0 && !((STRICT != 0) && multi_p0);
    idx_p0    = lowest_idx(bus.sel);
    data_p0   = bus.data_in[int'(idx_p0) * W +: W];
  end

  // ---- p0 -> p1: register selection and status ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out       <= '0;
      bus.src_idx   <= '0;
      bus.out_valid <= 1'b0;
      bus.changed   <= 1'b0;
      bus.conflict  <= 1'b0;
      bus.hold_cnt  <= '0;
    end else begin
      if (accept_p0) begin
        bus.out       <= data_p0;
        bus.src_idx   <= idx_p0;
        bus.out_valid <= 1'b1;
        bus.changed   <= 1'b1;
        bus.hold_cnt  <= '0;
      end else begin
        bus.changed   <= 1'b0;
        bus.hold_cnt  <= sat_inc(bus.hold_cnt);
      end
      // A new rejected multi-select outranks a simultaneous clear.
      if ((STRICT != 0) && multi_p0)
        bus.conflict <= 1'b1;
      else if (bus.clr_err)
        bus.conflict <= 1'b0;
    end
  end
endmodule

// File: tb/tb_onehot_mux_reg.sv
// Bench for onehot_mux_reg: a priority-select/CW=3 instance and a strict/CW=8
// instance share one stimulus stream and are checked against a behavioural model.
module tb_onehot_mux_reg;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] t_data;
  logic [3:0]  t_sel;
  logic        t_clr;

  int n_cmp = 0;
  int n_bad = 0;

  onehot_mux_reg_if #(.N(4), .W(8), .CW(3)) bus0 ();
  onehot_mux_reg_if #(.N(4), .W(8), .CW(8)) bus1 ();

  assign bus0.data_in = t_data;
  assign bus0.sel     = t_sel;
  assign bus0.clr_err = t_clr;
  assign bus1.data_in = t_data;
  assign bus1.sel     = t_sel;
  assign bus1.clr_err = t_clr;

  onehot_mux_reg #(.N(4), .W(8), .STRICT(0), .CW(3)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  onehot_mux_reg #(.N(4), .W(8), .STRICT(1), .CW(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: index 0 = priority/CW=3, index 1 = strict/CW=8.
  int  m_out[2], m_idx[2], m_valid[2], m_chg[2], m_conf[2], m_hold[2];
  int  m_max[2] = '{7, 255};
  bit  m_strict[2] = '{1'b0, 1'b1};
  bit  started = 1'b0;

  always @(posedge clk) begin
    int ones, first;
    bit take;
    ones  = $countones(t_sel);
    first = 0;
    for (int i = 3; i >= 0; i--) if (t_sel[i]) first = i;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_out[d] = 0; m_idx[d] = 0; m_valid[d] = 0;
        m_chg[d] = 0; m_conf[d] = 0; m_hold[d] = 0;
      end else begin
        take = (ones == 1) || (ones > 1 && !m_strict[d]);
        if (take) begin
          m_out[d]   = (t_data >> (8 * first)) & 32'hff;
          m_idx[d]   = first;
          m_valid[d] = 1;
          m_chg[d]   = 1;
          m_hold[d]  = 0;
        end else begin
          m_chg[d]  = 0;
          m_hold[d] = (m_hold[d] < m_max[d]) ? m_hold[d] + 1 : m_hold[d];
        end
        if (m_strict[d] && ones > 1) m_conf[d] = 1;
        else if (t_clr)              m_conf[d] = 0;
      end
    end
    started = 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("d0.out",       32'(bus0.out),       m_out[0]);
      check("d0.src_idx",   32'(bus0.src_idx),   m_idx[0]);
      check("d0.out_valid", 32'(bus0.out_valid), m_valid[0]);
      check("d0.changed",   32'(bus0.changed),   m_chg[0]);
      check("d0.conflict",  32'(bus0.conflict),  m_conf[0]);
      check("d0.hold_cnt",  32'(bus0.hold_cnt),  m_hold[0]);
      check("d1.out",       32'(bus1.out),       m_out[1]);
      check("d1.src_idx",   32'(bus1.src_idx),   m_idx[1]);
      check("d1.out_valid", 32'(bus1.out_valid), m_valid[1]);
      check("d1.changed",   32'(bus1.changed),   m_chg[1]);
      check("d1.conflict",  32'(bus1.conflict),  m_conf[1]);
      check("d1.hold_cnt",  32'(bus1.hold_cnt),  m_hold[1]);
    end
  end

  // Apply inputs, let one rising edge pass, return at the following falling edge.
  task automatic drive(input logic r, input logic [3:0] s, input logic c);
    rst   = r;
    t_sel = s;
    t_clr = c;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; t_sel = '0; t_clr = 1'b0; t_data = 32'h44332211;
    @(negedge clk);
    drive(1, 4'b0000, 0);

    for (int i = 0; i < 5; i++) begin
      drive(0, 4'b0000, 0);
      check("idle.changed", 32'(bus0.changed), 0);
    end
    check("idle.out",      32'(bus0.out),       0);
    check("idle.valid",    32'(bus0.out_valid), 0);
    check("idle.hold5",    32'(bus0.hold_cnt),  5);

    drive(0, 4'b0100, 0);
    check("cap.out",       32'(bus0.out),       32'h33);
    check("cap.idx",       32'(bus0.src_idx),   2);
    check("cap.changed",   32'(bus0.changed),   1);
    check("cap.valid",     32'(bus1.out_valid), 1);
    drive(0, 4'b0000, 0);
    check("hold.changed",  32'(bus0.changed),   0);
    check("hold.out",      32'(bus1.out),       32'h33);
    check("hold.cnt1",     32'(bus0.hold_cnt),  1);

    drive(0, 4'b1010, 0);
    check("prio.out",      32'(bus0.out),       32'h22);
    check("prio.idx",      32'(bus0.src_idx),   1);
    check("prio.conflict", 32'(bus0.conflict),  0);
    check("strict.out",    32'(bus1.out),       32'h33);
    check("strict.conf",   32'(bus1.conflict),  1);
    drive(0, 4'b0000, 1);
    check("clr.conf",      32'(bus1.conflict),  0);
    drive(0, 4'b0011, 1);
    check("setwins.conf",  32'(bus1.conflict),  1);
    check("prio.out11",    32'(bus0.out),       32'h11);

    for (int i = 0; i < 10; i++) drive(0, 4'b0000, 0);
    check("sat.hold7",     32'(bus0.hold_cnt),  7);
    drive(0, 4'b0001, 0);
    check("sat.hold0",     32'(bus0.hold_cnt),  0);

    drive(0, 4'b1000, 0);
    check("ch3.out",       32'(bus1.out),       32'h44);
    drive(1, 4'b1000, 1);
    check("rst.out",       32'(bus1.out),       0);
    check("rst.valid",     32'(bus1.out_valid), 0);
    check("rst.conf",      32'(bus1.conflict),  0);
    drive(0, 4'b1000, 0);
    check("post.out",      32'(bus1.out),       32'h44);
    check("post.changed",  32'(bus1.changed),   1);
    drive(0, 4'b1000, 0);
    check("recap.changed", 32'(bus1.changed),   1);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] s;
      logic       r;
      t_data = $urandom;
      case ($urandom_range(0, 3))
        0:       s = 4'b0000;
        1:       s = 4'b0001 << $urandom_range(0, 3);
        default: s = 4'($urandom);
      endcase
      r = ($urandom_range(0, 39) == 0);
      drive(r, s, ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 15) == 0)
        for (int k = 0; k < 12; k++) drive(0, 4'b0000, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/onehot_mux_reg.md
ONEHOT_MUX_REG -- requirements
Module: onehot_mux_reg

Interface
REQ-001 SHALL have parameter N, default 4, number of input channels (2..16).
REQ-002 SHALL have parameter W, default 8, data width per channel (1..32).
REQ-003 SHALL have parameter STRICT, default 0: 0 = priority select (lowest index wins), 1 = strict one-hot (multi-select rejected).
REQ-004 SHALL have parameter CW, default 8, hold-counter width.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 data_in  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
REQ-008 sel  input  N  select vector, bit i selects channel i.
REQ-009 clr_err  input  1  clears sticky conflict flag.
REQ-010 out  output  W  registered selected data.
REQ-011 out_valid  output  1  high once any channel has been captured since reset.
REQ-012 changed  output  1  one-cycle pulse on the cycle after a capture.
REQ-013 src_idx  output  $clog2(N)  index of channel last captured.
REQ-014 conflict  output  1  sticky multi-select flag.
REQ-015 hold_cnt  output  CW  cycles since last capture, saturating.

Function
REQ-016 Capture: on a rising edge with sel != 0 and the select accepted, out <= selected channel, src_idx <= its index, out_valid <= 1, changed <= 1, hold_cnt <= 0.
REQ-017 Hold: when sel == 0 or the select is rejected, out, src_idx and out_valid SHALL retain their values, changed <= 0, hold_cnt increments by 1.
REQ-018 hold_cnt SHALL saturate at 2^CW-1, never wrap.
REQ-019 STRICT=0: multiple sel bits set SHALL capture the lowest-index set channel; conflict SHALL NOT be set.
REQ-020 STRICT=1: more than one sel bit set SHALL be rejected (treated as hold) and conflict <= 1 on the same edge.
REQ-021 conflict SHALL remain set until clr_err or rst; clr_err with simultaneous new multi-select SHALL leave conflict = 1 (set wins).
REQ-022 Capture latency SHALL be exactly one clock: data and sel at edge k appear on out after edge k.
REQ-023 changed SHALL pulse on every capture, including recapture of the same channel with equal data.
REQ-024 Output SHALL be fully registered; no combinational path from data_in or sel to any output.
REQ-025 sel bits are sampled only at clock edges; no latches SHALL be inferred.

Reset
REQ-026 rst high at an edge SHALL force out = 0, src_idx = 0, out_valid = 0, changed = 0, conflict = 0, hold_cnt = 0, overriding sel and clr_err.
REQ-027 Reset asserted mid-operation SHALL discard held data; first capture after reset behaves as REQ-016.
REQ-028 While rst is high, hold_cnt SHALL stay 0.

Verification
REQ-029 Reset then sel=0 for 5 cycles -> out=0, out_valid=0, hold_cnt=5, changed never high.
REQ-030 N=4,W=8, data_in={8'h44,8'h33,8'h22,8'h11}, sel=4'b0100 one cycle -> next cycle out=8'h33, src_idx=2, changed=1, out_valid=1; following cycle with sel=0 changed=0, out=8'h33, hold_cnt=1.
REQ-031 STRICT=0, sel=4'b1010 -> out=data ch1 (8'h22), src_idx=1, conflict=0.
REQ-032 STRICT=1 after capturing 8'h33, sel=4'b1010 -> out stays 8'h33, conflict=1; sel=0 with clr_err=1 -> conflict=0 next cycle; clr_err=1 with sel=4'b0011 -> conflict stays 1.
REQ-033 CW=3, no capture for 10 cycles -> hold_cnt reaches 7 and holds 7; then sel=4'b0001 -> hold_cnt=0.
REQ-034 Capture 8'h44 (ch3), assert rst one cycle with sel=4'b1000 -> out=0, out_valid=0, conflict=0; next capture restores normal behaviour.
